// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage responder issuing one req/ack data-memory transaction per aligned load/store
// Ports: clk/rst (async active-low); ex_valid, MemRead_2ff, MemWrt_2ff, ALU_Out, RTData_2ff, nHaltSig from execute;
//        mem_req/mem_wr/mem_addr/mem_wdata out, mem_ack/mem_rdata in; Stall upstream; wb_valid/wb_data/Err to writeback.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          MemRead_2ff,
  input  logic          MemWrt_2ff,
  input  logic [AW-1:0] ALU_Out,
  input  logic [AW-1:0] RTData_2ff,
  input  logic          nHaltSig,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [AW-1:0] mem_rdata,
  output logic          Stall,
  output logic          wb_valid,
  output logic [AW-1:0] wb_data,
  output logic          Err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t     state_q;
  logic [7:0] timer_q;
  logic       mem_op;
  assign mem_op  = ex_valid & nHaltSig & (MemRead_2ff | MemWrt_2ff);
  assign mem_req = state_q == REQ;
  // Stall rises in the accepting cycle so upstream holds the bundle immediately
  assign Stall   = ((state_q == IDLE) & mem_op & !ALU_Out[0]) | (state_q == REQ) | (state_q == WAIT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      Err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        IDLE:
          if (mem_op && !ALU_Out[0]) begin
            state_q   <= REQ;
            mem_wr    <= MemWrt_2ff;
            mem_addr  <= ALU_Out;
            mem_wdata <= RTData_2ff;
          end else if (ex_valid) begin
            wb_valid <= 1'b1;
            wb_data  <= ALU_Out;
            Err      <= mem_op;
          end
        REQ: begin
          state_q <= WAIT;
          timer_q <= 8'd1;
        end
        WAIT:
          if (mem_ack) begin
            state_q  <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= mem_wr ? mem_addr : mem_rdata;
            Err      <= 1'b0;
          end else if (timer_q >= 8'(TIMEOUT)) begin
            state_q  <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= mem_addr;
            Err      <= 1'b1;
          end else if (timer_q != 8'hFF) timer_q <= timer_q + 8'd1;
        DONE: begin
          state_q <= IDLE;
          timer_q <= 8'd0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl with a delayed-ack memory model
module tb_mem_stage_ctrl;
  localparam int AW = 16;
  localparam int TO = 4;
  logic          clk = 1'b0, rst = 1'b0;
  logic          ex_valid = 1'b0, MemRead_2ff = 1'b0, MemWrt_2ff = 1'b0, nHaltSig = 1'b1;
  logic [AW-1:0] ALU_Out = '0, RTData_2ff = '0, mem_rdata = '0;
  logic          mem_ack;
  logic          mem_req, mem_wr, Stall, wb_valid, Err;
  logic [AW-1:0] mem_addr, mem_wdata, wb_data;
  int            n_tests = 0, n_fail = 0, stall_cnt = 0, req_cnt = 0, wb_cnt = 0, ack_dly = 0;
  typedef struct packed {logic [AW-1:0] d; logic e;} wb_t;
  typedef struct packed {logic w; logic [AW-1:0] a; logic [AW-1:0] wd;} mr_t;
  wb_t wb_q[$];
  mr_t mr_q[$];
  wb_t wx;
  mr_t mx;
  mem_stage_ctrl #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .MemRead_2ff(MemRead_2ff), .MemWrt_2ff(MemWrt_2ff),
    .ALU_Out(ALU_Out), .RTData_2ff(RTData_2ff), .nHaltSig(nHaltSig), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Stall(Stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .Err(Err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) cnt = ack_dly;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mem_ack = 1'b1;
      end
    end
  end
  always @(negedge clk)
    if (rst) begin
      if (Stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (mr_q.size() == 0) chk("mem_req_unexpected", 1, 0);
        else begin
          mx = mr_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(mx.a));
          chk("mem_wr", 32'(mem_wr), 32'(mx.w));
          if (mx.w) chk("mem_wdata", 32'(mem_wdata), 32'(mx.wd));
        end
      end
      if (wb_valid) begin
        wb_cnt++;
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          wx = wb_q.pop_front();
          chk("wb_data", 32'(wb_data), 32'(wx.d));
          chk("wb_err", 32'(Err), 32'(wx.e));
        end
      end
    end
  task automatic run(input string tag, input logic rd, input logic wr, input logic [AW-1:0] alu,
                     input logic [AW-1:0] rt, input logic hn, input int dly, input logic [AW-1:0] rdat,
                     input logic [AW-1:0] expd, input logic expe, input logic memop, input int exp_stall);
    int s, r;
    @(posedge clk); #1;
    ack_dly = dly;
    mem_rdata = rdat;
    s = stall_cnt;
    r = req_cnt;
    ex_valid = 1'b1; MemRead_2ff = rd; MemWrt_2ff = wr; ALU_Out = alu; RTData_2ff = rt; nHaltSig = hn;
    wb_q.push_back({expd, expe});
    if (memop) mr_q.push_back({wr, alu, rt});
    @(posedge clk); #1;
    ex_valid = 1'b0; MemRead_2ff = 1'b0; MemWrt_2ff = 1'b0; nHaltSig = 1'b1;
    for (int i = 0; i < 40 && wb_q.size() != 0; i++) @(posedge clk);
    chk({tag, "_wb_pending"}, 32'(wb_q.size()), 0);
    chk({tag, "_stall_cycles"}, 32'(stall_cnt - s), 32'(exp_stall));
    chk({tag, "_req_pulses"}, 32'(req_cnt - r), 32'(memop));
    @(posedge clk);
  endtask
  initial begin
    int w0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    @(negedge clk) rst = 1'b1;
    run("alu",      0, 0, 16'h1234, 16'h0000, 1, 0, 16'h0000, 16'h1234, 0, 0, 0);
    run("load",     1, 0, 16'h0040, 16'h0000, 1, 2, 16'hBEEF, 16'hBEEF, 0, 1, 4);
    run("store",    0, 1, 16'h0010, 16'hA5A5, 1, 1, 16'hDEAD, 16'h0010, 0, 1, 3);
    run("misalign", 1, 0, 16'h0013, 16'h0000, 1, 1, 16'h0000, 16'h0013, 1, 0, 0);
    run("both_wr",  1, 1, 16'h0020, 16'h1111, 1, 1, 16'hDEAD, 16'h0020, 0, 1, 3);
    run("ack_at_to",1, 0, 16'h0050, 16'h0000, 1, TO, 16'hCAFE, 16'hCAFE, 0, 1, TO + 2);
    run("timeout",  1, 0, 16'h0060, 16'h0000, 1, 0, 16'h7777, 16'h0060, 1, 1, TO + 2);
    run("alu2",     0, 0, 16'h5678, 16'h0000, 1, 0, 16'h0000, 16'h5678, 0, 0, 0);
    run("halt",     1, 0, 16'h0044, 16'h0000, 0, 1, 16'h9999, 16'h0044, 0, 0, 0);
    @(posedge clk); #1;
    ack_dly = 4;
    mem_rdata = 16'h4321;
    w0 = wb_cnt;
    ex_valid = 1'b1; MemRead_2ff = 1'b1; ALU_Out = 16'h0070;
    mr_q.push_back({1'b0, 16'h0070, 16'h0000});
    @(posedge clk); #1;
    ex_valid = 1'b0; MemRead_2ff = 1'b0;
    @(posedge clk); #1;
    chk("wait_stall", 32'(Stall), 1);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_stall", 32'(Stall), 0);
    chk("arst_wb_valid", 32'(wb_valid), 0);
    chk("arst_wb_data", 32'(wb_data), 0);
    chk("arst_err", 32'(Err), 0);
    chk("arst_mem_addr", 32'(mem_addr), 0);
    chk("arst_mem_wr", 32'(mem_wr), 0);
    chk("arst_mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (8) @(posedge clk);
    chk("late_ack_wb", 32'(wb_cnt - w0), 0);
    chk("late_ack_mrq", 32'(mr_q.size()), 0);
    run("post_rst", 0, 0, 16'h0BAD, 16'h0000, 1, 0, 16'h0000, 16'h0BAD, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
